div_clk_monitor: RTL and testbench

Measures the half-period of a slow, divided clock-like signal in cycles of the fast system clock. It declares lock when consecutive half-periods fall within tolerance of an expected value, and flags loss when edges stop. It sits downstream of the frequency dividers and checks their output, including feedback from off-chip loops, so that control logic can qualify the derived clocks. Default EXP_HALF=500 matches the team's standard divider, which toggles every 500 CLK cycles.

---
 rtl/div_clk_monitor.sv | 154 +++++++++++++++
 tb/tb_div_clk_monitor.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/div_clk_monitor.sv
// rtl/div_clk_monitor.sv - half-period meter and lock/loss detector for a divided clock
// Counts CLK cycles between SigIn transitions and qualifies them against EXP_HALF +/- TOL.
module div_clk_monitor #(
  parameter int CNT_W    = 16,
  parameter int EXP_HALF = 500,
  parameter int TOL      = 4,
  parameter int LOCK_N   = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             SigIn,
  output logic [CNT_W-1:0] HalfPeriod,
  output logic             Valid,
  output logic             Locked,
  output logic             Lost
);

  localparam int MW = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   EXP_X     = (CNT_W+1)'(EXP_HALF);
  localparam logic [CNT_W:0]   TOL_X     = (CNT_W+1)'(TOL);
  localparam logic [MW-1:0]    LOCK_C    = MW'(LOCK_N);

  typedef enum logic [2:0] {IDLE, ACQ, TRACK, LOCKED, LOST} state_t;

  state_t           state, state_nx;
  logic             s1, s2, s3;
  logic             sig_edge;
  logic [CNT_W-1:0] cnt, cnt_nx, meas, hp_nx;
  logic [MW-1:0]    match, match_nx;
  logic             valid_nx, locked_nx, lost_nx;
  logic [CNT_W:0]   meas_x, diff;
  logic             in_tol, timeout;

  assign sig_edge = s2 ^ s3;
  // Saturating increment doubles as the measured interval on an edge cycle.
  assign meas     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign meas_x   = {1'b0, meas};
  assign diff     = (meas_x >= EXP_X) ? (meas_x - EXP_X) : (EXP_X - meas_x);
  assign in_tol   = (diff <= TOL_X);
  assign timeout  = (cnt == TIMEOUT_C);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      match      <= '0;
      HalfPeriod <= '0;
      Valid      <= 1'b0;
      Locked     <= 1'b0;
      Lost       <= 1'b0;
    end else begin
      s1         <= SigIn;
      s2         <= s1;
      s3         <= s2;
      state      <= state_nx;
      cnt        <= cnt_nx;
      match      <= match_nx;
      HalfPeriod <= hp_nx;
      Valid      <= valid_nx;
      Locked     <= locked_nx;
      Lost       <= lost_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = sig_edge ? '0 : meas;
    match_nx  = match;
    hp_nx     = HalfPeriod;
    valid_nx  = 1'b0;
    locked_nx = Locked;
    lost_nx   = Lost;

    if (!Enable) begin
      state_nx  = IDLE;
      cnt_nx    = '0;
      match_nx  = '0;
      locked_nx = 1'b0;
      lost_nx   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nx    = '0;
          match_nx  = '0;
          locked_nx = 1'b0;
          lost_nx   = 1'b0;
          state_nx  = ACQ;
        end
        // First edge only starts the count; the interval before it is partial.
        ACQ: begin
          if (sig_edge) begin
            state_nx = TRACK;
          end else if (timeout) begin
            state_nx = LOST;
            lost_nx  = 1'b1;
          end
        end
        TRACK: begin
          if (sig_edge) begin
            valid_nx = 1'b1;
            hp_nx    = meas;
            if (in_tol) begin
              if (match + 1'b1 >= LOCK_C) begin
                match_nx  = LOCK_C;
                locked_nx = 1'b1;
                state_nx  = LOCKED;
              end else begin
                match_nx = match + 1'b1;
              end
            end else begin
              match_nx = '0;
            end
          end else if (timeout) begin
            state_nx  = LOST;
            lost_nx   = 1'b1;
            locked_nx = 1'b0;
            match_nx  = '0;
          end
        end
        LOCKED: begin
          if (sig_edge) begin
            valid_nx = 1'b1;
            hp_nx    = meas;
            if (!in_tol) begin
              locked_nx = 1'b0;
              match_nx  = '0;
              state_nx  = TRACK;
            end
          end else if (timeout) begin
            state_nx  = LOST;
            lost_nx   = 1'b1;
            locked_nx = 1'b0;
            match_nx  = '0;
          end
        end
        LOST: begin
          if (sig_edge) begin
            lost_nx  = 1'b0;
            state_nx = TRACK;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_clk_monitor.sv
// tb/tb_div_clk_monitor.sv - directed scoreboard bench for div_clk_monitor
// Each SigIn toggle that should yield Valid pushes cycle/HalfPeriod/Locked; a negedge monitor pops and compares.
module tb_div_clk_monitor;

  logic        CLK = 1'b0;
  logic        Reset, Enable, SigIn;
  logic [15:0] HalfPeriod;
  logic        Valid, Locked, Lost;

  div_clk_monitor #(
    .CNT_W(16), .EXP_HALF(500), .TOL(4), .LOCK_N(4), .TIMEOUT(1000)
  ) dut (
    .CLK(CLK), .Reset(Reset), .Enable(Enable), .SigIn(SigIn),
    .HalfPeriod(HalfPeriod), .Valid(Valid), .Locked(Locked), .Lost(Lost)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    logic [15:0] hp;
    logic        lk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   last_tog = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  logic prev_valid = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Toggle SigIn h cycles after the previous toggle; Valid is due 3 posedges later.
  task automatic half(input int h, input bit expv, input logic lk);
    tick(last_tog + h - cyc);
    SigIn = ~SigIn;
    last_tog = cyc;
    if (expv) sb.push_back('{cyc + 3, 16'(h), lk});
  endtask

  always @(negedge CLK) begin
    if (Valid) begin
      check("valid_back_to_back", {31'd0, prev_valid}, 32'd0);
      check("valid_expected", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("valid_cycle", cyc, mon_e.cyc);
        check("half_period", {16'd0, HalfPeriod}, {16'd0, mon_e.hp});
        check("locked_at_valid", {31'd0, Locked}, {31'd0, mon_e.lk});
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      check("missing_valid", cyc, mon_e.cyc);
    end
    prev_valid = Valid;
  end

  initial begin
    Reset = 1'b1; Enable = 1'b0; SigIn = 1'b0;
    tick(3);
    check("rst_halfperiod", {16'd0, HalfPeriod}, 32'd0);
    check("rst_valid", {31'd0, Valid}, 32'd0);
    check("rst_locked", {31'd0, Locked}, 32'd0);
    check("rst_lost", {31'd0, Lost}, 32'd0);
    Reset = 1'b0;
    tick(2);
    Enable = 1'b1;
    tick(3);

    // Reach TRACK, then hit it with an asynchronous reset between edges
    last_tog = cyc;
    half(5, 0, 1'b0);
    half(500, 1, 1'b0);
    tick(10);
    #3 Reset = 1'b1;
    #1;
    check("async_rst_halfperiod", {16'd0, HalfPeriod}, 32'd0);
    check("async_rst_valid", {31'd0, Valid}, 32'd0);
    check("async_rst_locked", {31'd0, Locked}, 32'd0);
    check("async_rst_lost", {31'd0, Lost}, 32'd0);
    tick(1);
    Reset = 1'b0;
    tick(3);

    // Acquisition: first edge silent, lock with the 4th Valid
    last_tog = cyc;
    half(5, 0, 1'b0);
    half(500, 1, 1'b0);
    half(500, 1, 1'b0);
    half(500, 1, 1'b0);
    half(500, 1, 1'b1);
    tick(10);
    check("locked_after_acq", {31'd0, Locked}, 32'd1);
    check("lost_after_acq", {31'd0, Lost}, 32'd0);

    // Tolerance edges: 503 and 496 keep lock, 505 drops it
    half(503, 1, 1'b1);
    half(496, 1, 1'b1);
    half(505, 1, 1'b0);
    tick(10);
    check("unlocked_after_505", {31'd0, Locked}, 32'd0);
    half(500, 1, 1'b0);
    half(500, 1, 1'b0);
    half(500, 1, 1'b0);
    half(500, 1, 1'b1);
    tick(10);
    check("relocked", {31'd0, Locked}, 32'd1);

    // Loss: Lost rises exactly when cnt reaches TIMEOUT
    tick(last_tog + 1003 - cyc);
    check("lost_before_timeout", {31'd0, Lost}, 32'd0);
    check("locked_before_timeout", {31'd0, Locked}, 32'd1);
    tick(1);
    check("lost_at_timeout", {31'd0, Lost}, 32'd1);
    check("locked_dropped_at_timeout", {31'd0, Locked}, 32'd0);
    tick(20);
    half(0, 0, 1'b0);
    tick(2);
    check("lost_held_before_edge", {31'd0, Lost}, 32'd1);
    tick(1);
    check("lost_cleared_by_edge", {31'd0, Lost}, 32'd0);
    half(500, 1, 1'b0);
    half(500, 1, 1'b0);
    half(500, 1, 1'b0);
    half(500, 1, 1'b1);
    tick(10);
    check("locked_after_recovery", {31'd0, Locked}, 32'd1);

    // Edge coinciding with cnt==TIMEOUT wins over the timeout
    half(1001, 1, 1'b0);
    tick(10);
    check("no_lost_on_coincident_edge", {31'd0, Lost}, 32'd0);
    check("unlocked_after_1001", {31'd0, Locked}, 32'd0);
    half(500, 1, 1'b0);
    half(500, 1, 1'b0);
    half(500, 1, 1'b0);
    half(500, 1, 1'b1);
    tick(10);
    check("locked_before_disable", {31'd0, Locked}, 32'd1);

    // Enable dropped in the edge cycle while LOCKED
    half(500, 0, 1'b0);
    tick(2);
    Enable = 1'b0;
    tick(1);
    check("no_valid_on_disable", {31'd0, Valid}, 32'd0);
    check("locked_cleared_on_disable", {31'd0, Locked}, 32'd0);
    tick(20);
    Enable = 1'b1;
    tick(5);
    half(30, 0, 1'b0);
    half(500, 1, 1'b0);
    tick(10);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("lost_final", {31'd0, Lost}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
